// File: rtl/ddr3_traffic_generator.sv
// ---------------------------------------------------------------------------
// ddr3_traffic_generator
//
// Memory bring-up traffic source for the Avalon-MM command port of the DDR3
// controller. After init and calibration it writes a known pattern to every
// word of the tested region. It then reads the region back in address order,
// with a bounded number of reads in flight. The read data is checked
// elsewhere; this block only issues requests and counts read completions.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   ddr3_init_done        controller init complete
//   ddr3_cal_success      calibration passed
//   ddr3_cal_fail         calibration failed
//   avl_ready             controller accepts the presented request
//   avl_rdata_valid       one read word returned this cycle
//   avl_burstbegin        first cycle of each newly presented request
//   avl_addr              word address
//   avl_wdata             write data (pattern for the address)
//   avl_be / avl_size     constant byte enables / burst size
//   avl_write_req         write request
//   avl_read_req          read request
//   writes_done           sticky, every write accepted
//   reads_done            sticky, every read accepted and returned
//   error                 sticky, calibration failed
// ---------------------------------------------------------------------------
module ddr3_traffic_generator #(
   parameter int WORD_COUNT_LOG2 = 24,
   parameter int ADDR_WIDTH      = 24,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ddr3_init_done,
   input  logic                  ddr3_cal_success,
   input  logic                  ddr3_cal_fail,
   input  logic                  avl_ready,
   input  logic                  avl_rdata_valid,
   output logic                  avl_burstbegin,
   output logic [ADDR_WIDTH-1:0] avl_addr,
   output logic [63:0]           avl_wdata,
   output logic [7:0]            avl_be,
   output logic [2:0]            avl_size,
   output logic                  avl_write_req,
   output logic                  avl_read_req,
   output logic                  writes_done,
   output logic                  reads_done,
   output logic                  error
);

   localparam int         CW      = WORD_COUNT_LOG2 + 1;
   localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      ST_WAIT_INIT = 3'd0,
      ST_WRITE     = 3'd1,
      ST_READ      = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_DONE      = 3'd4,
      ST_ERROR     = 3'd5
   } state_t;

   // Data pattern written to word index idx.
   function automatic logic [63:0] word_pattern(input logic [WORD_COUNT_LOG2-1:0] idx);
      return 64'hdeadfadebabebeef ^ 64'(idx);
   endfunction

   state_t                  state_r, state_s;
   logic [CW-1:0]           cnt_r, cnt_s, cnt_inc_s;
   logic [7:0]              outstanding_r, outstanding_s;
   logic                    write_req_r, write_req_s;
   logic                    read_req_r, read_req_s;
   logic                    burstbegin_r, burstbegin_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
   logic [63:0]             wdata_r, wdata_s;
   logic                    writes_done_r, writes_done_s;
   logic                    reads_done_r, reads_done_s;
   logic                    error_r, error_s;
   logic                    write_acc_s, read_acc_s, hold_s;

   assign write_acc_s = write_req_r & avl_ready;
   assign read_acc_s  = read_req_r & avl_ready;
   // A request presented last cycle and not taken is still the same request.
   assign hold_s      = (write_req_r | read_req_r) & ~avl_ready;

   // Reads in flight: +1 on acceptance, -1 on return, never below zero.
   always_comb begin
      outstanding_s = outstanding_r;
      if (read_acc_s && !avl_rdata_valid) begin
         outstanding_s = outstanding_r + 8'd1;
      end else if (!read_acc_s && avl_rdata_valid && (outstanding_r != 8'd0)) begin
         outstanding_s = outstanding_r - 8'd1;
      end else begin
         outstanding_s = outstanding_r;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      cnt_inc_s     = cnt_r;
      write_req_s   = 1'b0;
      read_req_s    = 1'b0;
      addr_s        = addr_r;
      wdata_s       = wdata_r;
      writes_done_s = writes_done_r;
      reads_done_s  = reads_done_r;
      error_s       = error_r;
      case (state_r)
         ST_WAIT_INIT: begin
            if (ddr3_init_done && ddr3_cal_success) begin
               state_s     = ST_WRITE;
               write_req_s = 1'b1;
               addr_s      = ADDR_WIDTH'(cnt_r[WORD_COUNT_LOG2-1:0]);
               wdata_s     = word_pattern(cnt_r[WORD_COUNT_LOG2-1:0]);
            end else if (ddr3_init_done && ddr3_cal_fail) begin
               state_s = ST_ERROR;
               error_s = 1'b1;
            end else begin
               state_s = ST_WAIT_INIT;
            end
         end
         ST_WRITE: begin
            cnt_inc_s = cnt_r + {{WORD_COUNT_LOG2{1'b0}}, write_acc_s};
            if (cnt_inc_s[CW-1]) begin
               // Last write taken: first read goes out immediately.
               cnt_s         = {CW{1'b0}};
               writes_done_s = 1'b1;
               state_s       = ST_READ;
               read_req_s    = (outstanding_s < MAX_OUT);
               addr_s        = {ADDR_WIDTH{1'b0}};
            end else begin
               cnt_s       = cnt_inc_s;
               write_req_s = 1'b1;
               addr_s      = ADDR_WIDTH'(cnt_inc_s[WORD_COUNT_LOG2-1:0]);
               wdata_s     = word_pattern(cnt_inc_s[WORD_COUNT_LOG2-1:0]);
            end
         end
         ST_READ: begin
            cnt_inc_s = cnt_r + {{WORD_COUNT_LOG2{1'b0}}, read_acc_s};
            cnt_s     = cnt_inc_s;
            if (cnt_inc_s[CW-1]) begin
               state_s = ST_DRAIN;
            end else begin
               // Throttle on the post-update count so a return this cycle
               // reopens the window next cycle.
               read_req_s = (outstanding_s < MAX_OUT);
               addr_s     = ADDR_WIDTH'(cnt_inc_s[WORD_COUNT_LOG2-1:0]);
            end
         end
         ST_DRAIN: begin
            if (outstanding_r == 8'd0) begin
               reads_done_s = 1'b1;
               state_s      = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_s = ST_DONE;
         end
         ST_ERROR: begin
            state_s = ST_ERROR;
         end
         default: begin
            state_s = ST_WAIT_INIT;
         end
      endcase
      burstbegin_s = (write_req_s | read_req_s) & ~hold_s;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_WAIT_INIT;
         cnt_r         <= {CW{1'b0}};
         outstanding_r <= 8'd0;
         write_req_r   <= 1'b0;
         read_req_r    <= 1'b0;
         burstbegin_r  <= 1'b0;
         addr_r        <= {ADDR_WIDTH{1'b0}};
         wdata_r       <= 64'd0;
         writes_done_r <= 1'b0;
         reads_done_r  <= 1'b0;
         error_r       <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         outstanding_r <= outstanding_s;
         write_req_r   <= write_req_s;
         read_req_r    <= read_req_s;
         burstbegin_r  <= burstbegin_s;
         addr_r        <= addr_s;
         wdata_r       <= wdata_s;
         writes_done_r <= writes_done_s;
         reads_done_r  <= reads_done_s;
         error_r       <= error_s;
      end
   end

   assign avl_burstbegin = burstbegin_r;
   assign avl_addr       = addr_r;
   assign avl_wdata      = wdata_r;
   assign avl_be         = 8'hff;
   assign avl_size       = 3'd1;
   assign avl_write_req  = write_req_r;
   assign avl_read_req   = read_req_r;
   assign writes_done    = writes_done_r;
   assign reads_done     = reads_done_r;
   assign error          = error_r;

endmodule

// File: tb/tb_ddr3_traffic_generator.sv
// ---------------------------------------------------------------------------
// Directed bench for ddr3_traffic_generator (16 words, 4 reads in flight).
// A per-cycle task samples outputs on the falling edge, checks request
// protocol against a small address/data model, then drives the inputs for
// the next rising edge.
// ---------------------------------------------------------------------------
module tb_ddr3_traffic_generator;

   localparam int N     = 4;
   localparam int AW    = 6;
   localparam int MAXO  = 4;
   localparam int WORDS = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ddr3_init_done = 1'b0;
   logic          ddr3_cal_success = 1'b0;
   logic          ddr3_cal_fail = 1'b0;
   logic          avl_ready = 1'b0;
   logic          avl_rdata_valid = 1'b0;
   logic          avl_burstbegin;
   logic [AW-1:0] avl_addr;
   logic [63:0]   avl_wdata;
   logic [7:0]    avl_be;
   logic [2:0]    avl_size;
   logic          avl_write_req;
   logic          avl_read_req;
   logic          writes_done;
   logic          reads_done;
   logic          error;

   always #5 clk = ~clk;

   ddr3_traffic_generator #(
      .WORD_COUNT_LOG2 (N),
      .ADDR_WIDTH      (AW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ddr3_init_done   (ddr3_init_done),
      .ddr3_cal_success (ddr3_cal_success),
      .ddr3_cal_fail    (ddr3_cal_fail),
      .avl_ready        (avl_ready),
      .avl_rdata_valid  (avl_rdata_valid),
      .avl_burstbegin   (avl_burstbegin),
      .avl_addr         (avl_addr),
      .avl_wdata        (avl_wdata),
      .avl_be           (avl_be),
      .avl_size         (avl_size),
      .avl_write_req    (avl_write_req),
      .avl_read_req     (avl_read_req),
      .writes_done      (writes_done),
      .reads_done       (reads_done),
      .error            (error)
   );

   int checks = 0;
   int errors = 0;

   // Bench model state
   int          cyc, exp_wr, exp_rd, n_wr_bb, n_rd_bb, outs, n_req;
   int          first_wr_cyc, last_wr_cyc, first_rd_cyc, wd_cyc, rdone_cyc, last_rv_cyc;
   logic [4:0]  pipe;
   bit          rand_ready, ret_en, stray_en, force_rv;
   logic        prev_pend, prev_wr, prev_rd;
   logic [AW-1:0] prev_addr;
   logic [63:0] prev_wdata, data3;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int a);
      logic [63:0] v;
      v = a;
      return 64'hdeadfadebabebeef ^ v;
   endfunction

   task automatic reset_model();
      cyc = 0; exp_wr = 0; exp_rd = 0; n_wr_bb = 0; n_rd_bb = 0; outs = 0; n_req = 0;
      first_wr_cyc = -1; last_wr_cyc = -1; first_rd_cyc = -1;
      wd_cyc = -1; rdone_cyc = -1; last_rv_cyc = -1;
      pipe = 5'd0; force_rv = 1'b0; prev_pend = 1'b0;
      prev_wr = 1'b0; prev_rd = 1'b0; prev_addr = '0; prev_wdata = 64'd0; data3 = 64'd0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_bb"},    avl_burstbegin, 64'd0);
      check_eq({tag, "_addr"},  avl_addr, 64'd0);
      check_eq({tag, "_wdata"}, avl_wdata, 64'd0);
      check_eq({tag, "_be"},    avl_be, 64'hff);
      check_eq({tag, "_size"},  avl_size, 64'd1);
      check_eq({tag, "_wreq"},  avl_write_req, 64'd0);
      check_eq({tag, "_rreq"},  avl_read_req, 64'd0);
      check_eq({tag, "_wdone"}, writes_done, 64'd0);
      check_eq({tag, "_rdone"}, reads_done, 64'd0);
      check_eq({tag, "_err"},   error, 64'd0);
   endtask

   // Assert reset right now, check outputs clear without a clock edge, release.
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
      avl_ready = 1'b0; avl_rdata_valid = 1'b0;
      #1 check_reset_outputs(tag);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      reset_model();
   endtask

   task automatic start_cal(input logic succ, input logic fail);
      ddr3_init_done = 1'b1; ddr3_cal_success = succ; ddr3_cal_fail = fail;
   endtask

   // One clock: observe and check outputs, then drive inputs for next edge.
   task automatic tick();
      logic wr, rd, rdy, acc_r, rv;
      @(negedge clk);
      cyc++;
      wr = avl_write_req;
      rd = avl_read_req;
      if (wr || rd) n_req++;
      if (wr && rd) check_eq("both_req", 64'd1, 64'd0);
      if (prev_pend) begin
         check_eq("hold_req",   {wr, rd}, {prev_wr, prev_rd});
         check_eq("hold_addr",  avl_addr, prev_addr);
         check_eq("hold_wdata", avl_wdata, prev_wdata);
         check_eq("hold_bb",    avl_burstbegin, 64'd0);
      end else begin
         check_eq("bb_new", avl_burstbegin, wr | rd);
      end
      if (avl_burstbegin && wr) n_wr_bb++;
      if (avl_burstbegin && rd) n_rd_bb++;
      if (writes_done && wd_cyc < 0) wd_cyc = cyc;
      if (reads_done && rdone_cyc < 0) rdone_cyc = cyc;
      if (rd && first_rd_cyc < 0) first_rd_cyc = cyc;

      rdy = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      avl_ready = rdy;
      if (wr && rdy) begin
         check_eq("wr_addr", avl_addr, exp_wr);
         check_eq("wr_data", avl_wdata, pat(exp_wr));
         if (exp_wr == 3) data3 = avl_wdata;
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         exp_wr++;
      end
      acc_r = rd && rdy;
      if (acc_r) begin
         check_eq("rd_addr", avl_addr, exp_rd);
         check_eq("rd_limit", (outs < MAXO), 64'd1);
         exp_rd++;
      end

      rv = 1'b0;
      if (ret_en && pipe[4]) begin
         rv = 1'b1;
         last_rv_cyc = cyc;
      end
      if (force_rv) rv = 1'b1;
      if (stray_en && exp_wr < WORDS && $urandom_range(0, 2) == 0) rv = 1'b1;
      force_rv = 1'b0;
      pipe = {pipe[3:0], acc_r};
      avl_rdata_valid = rv;
      if (acc_r && !rv) outs++;
      else if (!acc_r && rv && outs > 0) outs--;

      prev_pend = (wr || rd) && !rdy;
      prev_wr = wr; prev_rd = rd; prev_addr = avl_addr; prev_wdata = avl_wdata;
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && !reads_done; i++) tick();
      check_eq("reads_done_reached", reads_done, 64'd1);
   endtask

   task automatic final_checks(input string tag);
      check_eq({tag, "_n_wr"},  exp_wr, WORDS);
      check_eq({tag, "_n_rd"},  exp_rd, WORDS);
      check_eq({tag, "_wr_bb"}, n_wr_bb, WORDS);
      check_eq({tag, "_rd_bb"}, n_rd_bb, WORDS);
      check_eq({tag, "_wdone"}, writes_done, 64'd1);
      check_eq({tag, "_err"},   error, 64'd0);
   endtask

   initial begin
      rand_ready = 1'b0; ret_en = 1'b0; stray_en = 1'b0;
      reset_model();

      // Nominal: ready always high, 5-cycle read latency
      do_reset("rst0");
      ret_en = 1'b1;
      start_cal(1'b1, 1'b0);
      tick();
      check_eq("first_wr_req",  avl_write_req, 64'd1);
      check_eq("first_wr_addr", avl_addr, 64'd0);
      ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b1;   // must be ignored now
      run_until_done(400);
      final_checks("nom");
      check_eq("wr_no_bubble", last_wr_cyc - first_wr_cyc, WORDS - 1);
      check_eq("wr_to_rd",     first_rd_cyc, last_wr_cyc + 1);
      check_eq("wdone_rise",   wd_cyc, last_wr_cyc + 1);
      check_eq("rdone_rise",   rdone_cyc, last_rv_cyc + 2);
      check_eq("addr3_data",   data3, 64'hdeadfadebabebeec);
      n_req = 0;
      repeat (5) tick();
      check_eq("done_idle", n_req, 64'd0);

      // Backpressure plus stray rdata_valid while writing
      do_reset("rst1");
      ret_en = 1'b1; rand_ready = 1'b1; stray_en = 1'b1;
      start_cal(1'b1, 1'b0);
      run_until_done(1500);
      final_checks("bp");
      rand_ready = 1'b0; stray_en = 1'b0;

      // Throttle: no reads returned
      do_reset("rst2");
      ret_en = 1'b0;
      start_cal(1'b1, 1'b0);
      for (int i = 0; i < 100 && !writes_done; i++) tick();
      check_eq("thr_wdone", writes_done, 64'd1);
      repeat (20) tick();
      check_eq("thr_four", exp_rd, 64'd4);
      check_eq("thr_low",  avl_read_req, 64'd0);
      force_rv = 1'b1;
      tick();
      tick();
      check_eq("thr_resume", avl_read_req, 64'd1);
      repeat (10) tick();
      check_eq("thr_five",  exp_rd, 64'd5);
      check_eq("thr_low2",  avl_read_req, 64'd0);

      // Reset in the middle of READ at address 7
      do_reset("rst3");
      ret_en = 1'b1;
      start_cal(1'b1, 1'b0);
      for (int i = 0; i < 200 && !(avl_read_req && avl_addr == 7); i++) tick();
      check_eq("reach_rd7", (avl_read_req && avl_addr == 7), 64'd1);
      #1 do_reset("mid_rd");
      start_cal(1'b1, 1'b0);
      tick();
      check_eq("restart_req",  avl_write_req, 64'd1);
      check_eq("restart_addr", avl_addr, 64'd0);
      run_until_done(400);
      final_checks("rerun");

      // Calibration failure
      do_reset("rst4");
      start_cal(1'b0, 1'b1);
      tick();
      check_eq("err_next", error, 64'd1);
      ddr3_cal_success = 1'b1;
      repeat (10) tick();
      check_eq("err_no_req", n_req, 64'd0);
      check_eq("err_sticky", error, 64'd1);

      // Success and fail together selects the write path
      do_reset("rst5");
      start_cal(1'b1, 1'b1);
      tick();
      check_eq("both_cal_wr",  avl_write_req, 64'd1);
      check_eq("both_cal_err", error, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr3_traffic_generator.md
# ddr3_traffic_generator

Drives the Avalon-MM command side of the DDR3 controller for the memory bring-up test. After controller init and calibration it writes a pattern to every word of the tested region, then reads the whole region back with a bounded number of reads in flight. The read data itself is checked by the existing read-data checker, which expects exactly this pattern and order. This block only generates traffic and tracks read completions.

## Interface
Parameters:
- WORD_COUNT_LOG2, default 24: log2 of the number of 64-bit words tested, at addresses 0 .. 2^WORD_COUNT_LOG2-1.
- ADDR_WIDTH, default 24: width of avl_addr in words; must be >= WORD_COUNT_LOG2.
- MAX_OUTSTANDING, default 16: maximum reads accepted but not yet returned (1..255).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- ddr3_init_done  in  1  controller init complete.
- ddr3_cal_success  in  1  calibration passed.
- ddr3_cal_fail  in  1  calibration failed.
- avl_ready  in  1  controller accepts the presented request this cycle.
- avl_rdata_valid  in  1  one read word returned this cycle.
- avl_burstbegin  out  1  first cycle of each newly presented request.
- avl_addr  out  ADDR_WIDTH  word address.
- avl_wdata  out  64  write data.
- avl_be  out  8  byte enables, constant 8'hff.
- avl_size  out  3  burst size, constant 3'd1.
- avl_write_req  out  1  write request.
- avl_read_req  out  1  read request.
- writes_done  out  1  sticky; all writes accepted.
- reads_done  out  1  sticky; all reads accepted and returned.
- error  out  1  sticky; calibration failed.

## Operation
- Pattern for word address i: 64'hdeadfadebabebeef ^ zero-extended i.
- Counter: WORD_COUNT_LOG2+1 bits. The MSB set means the phase is complete.
- States:
  - WAIT_FOR_INIT: once ddr3_init_done is high, go to WRITE if ddr3_cal_success is high, else go to ERROR if ddr3_cal_fail is high. Success has priority if both are high.
  - WRITE: present a write at counter address with the pattern. On acceptance (avl_write_req && avl_ready), increment the counter. When the MSB sets: clear the counter, set writes_done, go to READ.
  - READ: present a read at counter address, but only while outstanding < MAX_OUTSTANDING. Increment the counter on acceptance. When the MSB sets, go to DRAIN.
  - DRAIN: wait until outstanding == 0, then set reads_done and go to DONE.
  - DONE, ERROR: all requests low forever. ERROR sets error.
- A presented request holds addr, wdata and req stable until it is accepted. Read_req and write_req are never both high.
- Outstanding counter: 8 bits.
  - +1 on read acceptance; −1 on avl_rdata_valid.
  - Both in the same cycle: unchanged.
  - Saturates at 0: a stray rdata_valid outside READ/DRAIN is ignored.
- avl_burstbegin is high only in a cycle where a request is asserted and it is not a continuation of an unaccepted request from the previous cycle.

## Timing
- Reset (asynchronous assert): all outputs 0; avl_be = 8'hff; avl_size = 3'd1; state WAIT_FOR_INIT; counters 0. Reset asserted mid-operation aborts immediately, with requests low in the same instant.
- All outputs are registered.
- First write request appears 1 cycle after the cycle in which init_done && cal_success is sampled high.
- With avl_ready held high: one write accepted per cycle with no bubbles, so 2^N writes take 2^N cycles.
- WRITE to READ transition: the first read is presented in the cycle after the last write is accepted. writes_done rises in that same cycle.
- Read throttle: when an acceptance makes outstanding reach MAX_OUTSTANDING, read_req is low the next cycle. A rdata_valid in cycle t permits a new read presentation in cycle t+1.
- reads_done rises 1 cycle after outstanding reaches 0 in DRAIN.
- Calibration inputs are ignored after leaving WAIT_FOR_INIT.

## Test plan
- Nominal (WORD_COUNT_LOG2=4, avl_ready=1, reads returned with 5-cycle latency):
  - 16 writes at addrs 0..15; addr 3 carries data 64'hdeadfadebabebeec.
  - Then 16 reads at 0..15.
  - writes_done rises, then reads_done; error stays 0; requests low in DONE.
- Backpressure: toggle avl_ready pseudo-randomly.
  - Each request is held stable until accepted.
  - burstbegin pulses exactly once per address: 16 write pulses, 16 read pulses.
  - No address is skipped or repeated.
- Throttle (MAX_OUTSTANDING=4, no rdata_valid returned):
  - Exactly 4 reads accepted, then read_req stays low.
  - One rdata_valid pulse is followed by exactly one more read.
- Calibration fail (init_done=1, cal_fail=1):
  - error=1 the next cycle; no request is ever asserted.
  - Both success and fail high selects WRITE.
- Reset mid-READ (addr 7): all outputs clear asynchronously. After release and re-calibration, writes restart at addr 0.
- Stray rdata_valid during WRITE: no effect; READ still issues all reads.
